pipeline_arbiter: RTL and testbench

Two-requester round-robin arbiter and flow controller for the shared `Pipeline` datapath (XLEN-wide, DEPTH-stage, global `stall`). It owns the pipeline's `data_in` and `stall` inputs, and tags every injected word with its requester ID. It routes `data_out` back to the originating response port and freezes the pipeline whenever the word at the last stage cannot be delivered. It sits between the two client blocks and one `Pipeline` instance.

---
 rtl/pipeline_arbiter_if.sv | 56 +++++
 rtl/pipeline_arbiter.sv | 84 ++++++++
 tb/tb_pipeline_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_arbiter_if.sv
// rtl/pipeline_arbiter_if.sv - handshake and datapath bundle between two clients, the arbiter and a Pipeline
//
// Purpose: groups the requester, response and Pipeline-facing signals of
// pipeline_arbiter so they travel as one port.
// Signals:
//   req0/1_valid, req0/1_data   client -> arbiter, word offered for injection
//   req0/1_ready                arbiter -> client, word accepted this edge
//   rsp0/1_valid, rsp0/1_data   arbiter -> client, result present (data 0 when idle)
//   rsp0/1_ready                client -> arbiter, result taken this edge
//   pipe_data_in, pipe_stall    arbiter -> Pipeline
//   pipe_data_out               Pipeline -> arbiter
//   occupancy                   arbiter -> observer, valid in-flight word count
// Modports: slave = arbiter side, master = client/Pipeline side.

interface pipeline_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             req0_valid;
   logic [XLEN-1:0]  req0_data;
   logic             req0_ready;
   logic             req1_valid;
   logic [XLEN-1:0]  req1_data;
   logic             req1_ready;

   logic             rsp0_valid;
   logic [XLEN-1:0]  rsp0_data;
   logic             rsp0_ready;
   logic             rsp1_valid;
   logic [XLEN-1:0]  rsp1_data;
   logic             rsp1_ready;

   logic [XLEN-1:0]  pipe_data_in;
   logic             pipe_stall;
   logic [XLEN-1:0]  pipe_data_out;

   logic [OCC_W-1:0] occupancy;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      input  rsp0_ready, rsp1_ready, pipe_data_out,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      output pipe_data_in, pipe_stall, occupancy
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      output rsp0_ready, rsp1_ready, pipe_data_out,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      input  pipe_data_in, pipe_stall, occupancy
   );
endinterface

// File: rtl/pipeline_arbiter.sv
// rtl/pipeline_arbiter.sv - two-requester round-robin arbiter and flow controller for a DEPTH-stage Pipeline
//
// Purpose: injects words from two requesters into a shared stallable Pipeline,
// tags each word with its requester ID, routes the last-stage word back to its
// owner and stalls the whole Pipeline while that owner is not ready.
// Ports:
//   clock   in   sole clock, rising edge
//   resetn  in   asynchronous active-low reset
//   bus     slave modport of pipeline_arbiter_if (requests, responses,
//           Pipeline data_in/stall/data_out, occupancy)

module pipeline_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 resetn,
   pipeline_arbiter_if.slave    bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   // Tag chain: bit i describes Pipeline stage i; bit DEPTH-1 describes data_out.
   logic [DEPTH-1:0] tag_vld;
   logic [DEPTH-1:0] tag_id;
   logic             last_q;
   logic [OCC_W-1:0] occ_q;

   logic head_vld;
   logic head_id;
   logic head_ready;
   logic head_blocked;
   logic advance;
   logic cand;
   logic grant;

   always_comb begin
      head_vld     = tag_vld[DEPTH-1];
      head_id      = tag_id[DEPTH-1];
      head_ready   = head_id ? bus.rsp1_ready : bus.rsp0_ready;
      head_blocked = head_vld & ~head_ready;
      advance      = ~head_blocked;

      // Contention goes to the port that did not win last; otherwise the
      // only requester is the candidate (port 0 when idle, unused then).
      cand = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         cand = ~last_q;
      end else if (bus.req1_valid) begin
         cand = 1'b1;
      end

      // No transfer is accepted while reset is held, so clients see ready=0.
      grant = (bus.req0_valid | bus.req1_valid) & advance & resetn;
   end

   assign bus.req0_ready   = grant & ~cand;
   assign bus.req1_ready   = grant &  cand;
   assign bus.pipe_data_in = ~grant ? '0 : (cand ? bus.req1_data : bus.req0_data);
   assign bus.pipe_stall   = head_blocked;

   assign bus.rsp0_valid   = head_vld & ~head_id;
   assign bus.rsp1_valid   = head_vld &  head_id;
   assign bus.rsp0_data    = bus.rsp0_valid ? bus.pipe_data_out : '0;
   assign bus.rsp1_data    = bus.rsp1_valid ? bus.pipe_data_out : '0;
   assign bus.occupancy    = occ_q;

   // The chain moves on exactly the edges the Pipeline samples (stall=0).
   // A valid head on an advance edge is the word being retired.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tag_vld <= '0;
         tag_id  <= '0;
         last_q  <= 1'b1;
         occ_q   <= '0;
      end else if (advance) begin
         tag_vld <= {tag_vld[DEPTH-2:0], grant};
         tag_id  <= {tag_id[DEPTH-2:0], grant & cand};
         occ_q   <= occ_q + OCC_W'(grant) - OCC_W'(head_vld);
         if (grant) begin
            last_q <= cand;
         end
      end
   end
endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb/tb_pipeline_arbiter.sv - self-checking bench for pipeline_arbiter with a behavioural Pipeline and scoreboard

module tb_pipeline_arbiter;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   pipeline_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   pipeline_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock  (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Behavioural Pipeline: no reset, so stale words survive an arbiter reset.
   logic [XLEN-1:0] stg [DEPTH];
   always @(posedge clk) begin
      if (!bus.pipe_stall) begin
         for (int i = DEPTH-1; i > 0; i--) stg[i] <= stg[i-1];
         stg[0] <= bus.pipe_data_in;
      end
   end
   assign bus.pipe_data_out = stg[DEPTH-1];

   int tests = 0;
   int fails = 0;
   int dcnt0 = 0;
   int dcnt1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: in-flight words in acceptance order, each with the number of
   // Pipeline advances it has seen. A word is on data_out once it has seen DEPTH-1.
   typedef struct {
      bit          id;
      logic [31:0] data;
      int          pos;
   } item_t;
   item_t fl[$];
   bit    m_last;

   task automatic model_eval(output bit e_r0, output bit e_r1, output bit e_v0, output bit e_v1,
                             output bit e_stall, output logic [31:0] e_d0, output logic [31:0] e_d1,
                             output logic [31:0] e_pin);
      bit head;
      bit hrdy;
      head = (fl.size() > 0) && (fl[0].pos == DEPTH-1);
      hrdy = head && (fl[0].id ? bus.rsp1_ready : bus.rsp0_ready);
      e_stall = head && !hrdy;
      e_v0 = head && fl[0].id == 1'b0;
      e_v1 = head && fl[0].id == 1'b1;
      e_d0 = e_v0 ? fl[0].data : 32'h0;
      e_d1 = e_v1 ? fl[0].data : 32'h0;
      e_r0 = !e_stall && bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
      e_r1 = !e_stall && bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
      e_pin = e_r0 ? bus.req0_data : (e_r1 ? bus.req1_data : 32'h0);
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fl.delete();
         m_last = 1'b1;
      end else begin
         bit r0, r1, v0, v1, st;
         logic [31:0] d0, d1, pin;
         item_t it;
         model_eval(r0, r1, v0, v1, st, d0, d1, pin);
         if (!st) begin
            if (fl.size() > 0 && fl[0].pos == DEPTH-1) void'(fl.pop_front());
            foreach (fl[i]) fl[i].pos++;
            if (r0 || r1) begin
               it.id   = r1;
               it.data = pin;
               it.pos  = 0;
               fl.push_back(it);
               m_last  = r1;
            end
         end
      end
   end

   // Compare process: every output, every cycle, away from the active edge.
   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_req0_ready", 32'(bus.req0_ready), 32'h0);
         chk("rst_req1_ready", 32'(bus.req1_ready), 32'h0);
         chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
         chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
         chk("rst_rsp0_data",  bus.rsp0_data, 32'h0);
         chk("rst_rsp1_data",  bus.rsp1_data, 32'h0);
         chk("rst_stall",      32'(bus.pipe_stall), 32'h0);
         chk("rst_pipe_in",    bus.pipe_data_in, 32'h0);
         chk("rst_occupancy",  32'(bus.occupancy), 32'h0);
      end else begin
         bit r0, r1, v0, v1, st;
         logic [31:0] d0, d1, pin;
         model_eval(r0, r1, v0, v1, st, d0, d1, pin);
         chk("req0_ready", 32'(bus.req0_ready), 32'(r0));
         chk("req1_ready", 32'(bus.req1_ready), 32'(r1));
         chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(v0));
         chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(v1));
         chk("rsp0_data",  bus.rsp0_data, d0);
         chk("rsp1_data",  bus.rsp1_data, d1);
         chk("pipe_stall", 32'(bus.pipe_stall), 32'(st));
         chk("pipe_data_in", bus.pipe_data_in, pin);
         chk("occupancy",  32'(bus.occupancy), 32'(fl.size()));
      end
   end

   // Delivery counters; inputs are stable from here until the next rising edge.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (bus.rsp0_valid && bus.rsp0_ready) dcnt0++;
         if (bus.rsp1_valid && bus.rsp1_ready) dcnt1++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_words(input int port, input logic [31:0] base, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         if (port == 0) begin bus.req0_valid = 1'b1; bus.req0_data = base + 32'(i); end
         else           begin bus.req1_valid = 1'b1; bus.req1_data = base + 32'(i); end
         @(negedge clk);
         while (!(port == 0 ? bus.req0_ready : bus.req1_ready) && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (w >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout port %0d: got ready=0 for 200 cycles, expected ready=1", port);
         end
         @(posedge clk);
         #1;
         if (port == 0) begin bus.req0_valid = 1'b0; bus.req0_data = 32'h0; end
         else           begin bus.req1_valid = 1'b0; bus.req1_data = 32'h0; end
         cyc(gap);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int s0, s1;
      bit found;
      resetn = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_data = 32'h0;
      bus.req1_valid = 1'b0; bus.req1_data = 32'h0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("lit_rst_occ", 32'(bus.occupancy), 32'h0);
      resetn = 1'b1;
      cyc(1);

      // Single request: latency DEPTH-1 edges, occupancy 1 -> 0.
      bus.req0_valid = 1'b1; bus.req0_data = 32'hDEADBEEF;
      #1 chk("t1_req0_ready", 32'(bus.req0_ready), 32'h1);
      cyc(1);
      bus.req0_valid = 1'b0; bus.req0_data = 32'h0;
      chk("t1_occ_inject", 32'(bus.occupancy), 32'h1);
      chk("t1_early0", 32'(bus.rsp0_valid), 32'h0);
      cyc(2);
      chk("t1_early1", 32'(bus.rsp0_valid), 32'h0);
      cyc(1);
      chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
      chk("t1_rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
      chk("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
      chk("t1_occ_head", 32'(bus.occupancy), 32'h1);
      cyc(1);
      chk("t1_occ_retired", 32'(bus.occupancy), 32'h0);
      chk("t1_rsp0_gone", 32'(bus.rsp0_valid), 32'h0);

      // Both requesters saturated.
      s0 = dcnt0; s1 = dcnt1;
      fork
         send_words(0, 32'h100, 8, 0);
         send_words(1, 32'h200, 8, 0);
         begin cyc(5); chk("t2_full_occ", 32'(bus.occupancy), 32'(DEPTH)); end
      join
      cyc(8);
      chk("t2_delivered0", 32'(dcnt0 - s0), 32'd8);
      chk("t2_delivered1", 32'(dcnt1 - s1), 32'd8);

      // Backpressure on port 0 for three cycles with a valid head.
      s0 = dcnt0;
      fork
         send_words(0, 32'h300, 8, 0);
         begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
               @(posedge clk);
               #1;
               if (bus.rsp0_valid) found = 1'b1;
            end
            chk("t3_head_seen", 32'(found), 32'h1);
            bus.rsp0_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               chk("t3_stall", 32'(bus.pipe_stall), 32'h1);
               chk("t3_req0_ready", 32'(bus.req0_ready), 32'h0);
               chk("t3_head_held", bus.rsp0_data, 32'h300);
               @(posedge clk);
            end
            #1;
            bus.rsp0_ready = 1'b1;
            #1 chk("t3_released", 32'(bus.pipe_stall), 32'h0);
         end
      join
      cyc(10);
      chk("t3_delivered", 32'(dcnt0 - s0), 32'd8);

      // Port 1 head blocked with a port 0 word behind it.
      bus.rsp1_ready = 1'b0;
      fork
         send_words(1, 32'hA1, 1, 0);
         send_words(0, 32'hB0, 1, 0);
      join
      cyc(5);
      chk("t4_stall", 32'(bus.pipe_stall), 32'h1);
      chk("t4_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
      chk("t4_rsp1_data", bus.rsp1_data, 32'hA1);
      chk("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
      chk("t4_occ", 32'(bus.occupancy), 32'h2);
      bus.rsp1_ready = 1'b1;
      #1 chk("t4_unstall", 32'(bus.pipe_stall), 32'h0);
      @(posedge clk);
      #1;
      chk("t4_rsp1_done", 32'(bus.rsp1_valid), 32'h0);
      chk("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
      chk("t4_rsp0_data", bus.rsp0_data, 32'hB0);
      cyc(3);

      // Sparse traffic: every third cycle on each port.
      s0 = dcnt0; s1 = dcnt1;
      fork
         send_words(0, 32'h500, 4, 2);
         send_words(1, 32'h540, 4, 2);
      join
      cyc(8);
      chk("t5_delivered0", 32'(dcnt0 - s0), 32'd4);
      chk("t5_delivered1", 32'(dcnt1 - s1), 32'd4);

      // Reset with three words in flight.
      s0 = dcnt0; s1 = dcnt1;
      send_words(0, 32'h600, 3, 0);
      chk("t6_occ3", 32'(bus.occupancy), 32'h3);
      bus.req0_valid = 1'b1; bus.req0_data = 32'h700;
      bus.req1_valid = 1'b1; bus.req1_data = 32'h800;
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_occ", 32'(bus.occupancy), 32'h0);
      chk("t6_async_rsp0", 32'(bus.rsp0_valid), 32'h0);
      chk("t6_async_stall", 32'(bus.pipe_stall), 32'h0);
      chk("t6_async_rdy0", 32'(bus.req0_ready), 32'h0);
      chk("t6_async_pin", bus.pipe_data_in, 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      #1;
      chk("t6_first_win0", 32'(bus.req0_ready), 32'h1);
      chk("t6_first_lose1", 32'(bus.req1_ready), 32'h0);
      chk("t6_pin", bus.pipe_data_in, 32'h700);
      fork
         send_words(0, 32'h700, 1, 0);
         send_words(1, 32'h800, 1, 0);
      join
      cyc(8);
      chk("t6_delivered0", 32'(dcnt0 - s0), 32'd1);
      chk("t6_delivered1", 32'(dcnt1 - s1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
